mult_product_accumulator: RTL and testbench

//  Downstream stage of the shift-and-add multiplier. Consumes a stream of m+n-bit products

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_product_accumulator_sat_adder.sv | 18 +
 rtl/mult_product_accumulator.sv | 129 ++++++++++++
 tb/tb_mult_product_accumulator.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared widths and state encoding for the shift-and-add multiplier pipeline.
`default_nettype none
package mult_pkg;
  localparam int M_DEFAULT = 8;
  localparam int N_DEFAULT = 8;
  localparam int PW        = M_DEFAULT + N_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage
`default_nettype wire

// File: rtl/mult_product_accumulator_sat_adder.sv
// sat_adder: unsigned a + b clamped to all-ones of width AW, with a saturation flag.
`default_nettype none
module sat_adder #(
  parameter int AW = 20,
  parameter int BW = 16
) (
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [AW-1:0] sum,
  output logic          sat
);
  logic [AW:0] wide;

  assign wide = {1'b0, a} + (AW+1)'(b);
  assign sat  = wide[AW];
  assign sum  = sat ? {AW{1'b1}} : wide[AW-1:0];
endmodule
`default_nettype wire

// File: rtl/mult_product_accumulator.sv
// mult_product_accumulator: sums up to TERMS products per group with saturation and
// hands each group result downstream over a valid/ready handshake.
`default_nettype none
module mult_product_accumulator
  import mult_pkg::*;
#(
  parameter int m     = M_DEFAULT,
  parameter int n     = N_DEFAULT,
  parameter int TERMS = 4,
  parameter int ACCW  = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [m+n-1:0]             in_prod,
  input  logic                       in_last,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACCW-1:0]            out_sum,
  output logic [$clog2(TERMS+1)-1:0] out_count,
  output logic                       out_ovf,
  output logic                       busy
);
  localparam int PWL = m + n;
  localparam int CW  = $clog2(TERMS+1);
  localparam logic [CW-1:0] TERMS_C = CW'(TERMS);

  state_t          state;
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            ovf;

  logic [ACCW-1:0] add_sum;
  logic            add_sat;
  logic            accept;
  logic [ACCW-1:0] first_val;
  logic [CW-1:0]   cnt_inc;
  logic            idle_close;
  logic            acc_close;
  logic            ovf_next;

  sat_adder #(.AW(ACCW), .BW(PWL)) u_sat_adder (
    .a   (acc),
    .b   (in_prod),
    .sum (add_sum),
    .sat (add_sat)
  );

  assign accept     = in_valid & in_ready;
  assign first_val  = ACCW'(in_prod);
  assign cnt_inc    = cnt + CW'(1);
  assign idle_close = in_last || (TERMS == 1);
  // A product that both carries in_last and fills the group closes it exactly once.
  assign acc_close  = (cnt_inc == TERMS_C) || in_last;
  assign ovf_next   = ovf | add_sat;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            acc <= first_val;
            cnt <= CW'(1);
            ovf <= 1'b0;
            if (idle_close) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= first_val;
              out_count <= CW'(1);
              out_ovf   <= 1'b0;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt_inc;
            ovf <= ovf_next;
            if (acc_close) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= add_sum;
              out_count <= cnt_inc;
              out_ovf   <= ovf_next;
            end
          end
        end
        DONE: begin
          // The transfer cycle itself is the bubble; ready returns one cycle later.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_mult_product_accumulator.sv
// Randomized and directed bench for mult_product_accumulator against a queue-free arithmetic model.
`default_nettype none
module tb_mult_product_accumulator;
  localparam int TERMS = 4;
  localparam int ACCW  = 17;
  localparam int CW    = $clog2(TERMS+1);
  localparam longint MAXV = (longint'(1) << ACCW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_prod;
  logic            in_last;
  logic            clear;
  logic            out_valid;
  logic            out_ready;
  logic [ACCW-1:0] out_sum;
  logic [CW-1:0]   out_count;
  logic            out_ovf;
  logic            busy;

  int vectors = 0;
  int miscompares = 0;

  mult_product_accumulator #(.m(8), .n(8), .TERMS(TERMS), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_last   (in_last),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one product and returns just after the edge that accepts it.
  task automatic send(input logic [15:0] p, input logic last);
    int waited = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_last  = last;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    vectors++;
    if (!in_ready) begin
      miscompares++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    vectors++;
    if ({out_valid, in_ready, busy, out_ovf} !== 4'b0 || out_sum !== '0 || out_count !== '0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%0b ready=%0b busy=%0b sum=%0d cnt=%0d required all 0",
               out_valid, in_ready, busy, out_sum, out_count);
    end
    rst = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready: in_ready=%0b required 0", in_ready);
    end
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_rise: in_ready=%0b required 1", in_ready);
    end
    send(16'd3, 1'b0);
    send(16'd4, 1'b0);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, busy, out_ovf} !== 4'b0 || out_sum !== '0 || out_count !== '0) begin
      miscompares++;
      $display("FAIL reset_midgroup: valid=%0b ready=%0b busy=%0b sum=%0d cnt=%0d required all 0",
               out_valid, in_ready, busy, out_sum, out_count);
    end
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_ready: in_ready=%0b required 1", in_ready);
    end
    send(16'd5, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== ACCW'(5) || out_count !== CW'(1)) begin
      miscompares++;
      $display("FAIL reset_next_group: valid=%0b sum=%0d cnt=%0d required 1 5 1",
               out_valid, out_sum, out_count);
    end
    take();
  endtask

  task automatic test_four_products();
    send(16'd15, 1'b0);
    send(16'd100, 1'b0);
    send(16'd255, 1'b0);
    send(16'd1, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== ACCW'(371) || out_count !== CW'(4) ||
        out_ovf !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL four_products: valid=%0b sum=%0d cnt=%0d ovf=%0b ready=%0b required 1 371 4 0 0",
               out_valid, out_sum, out_count, out_ovf, in_ready);
    end
    tick();
    tick();
    vectors++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL four_hold: ready=%0b valid=%0b required 0 1", in_ready, out_valid);
    end
    take();
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL four_release: valid=%0b ready=%0b busy=%0b required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_early_last();
    send(16'd65025, 1'b0);
    send(16'd65025, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== ACCW'(130050) || out_count !== CW'(2) || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL early_last: valid=%0b sum=%0d cnt=%0d ovf=%0b required 1 130050 2 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    take();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 4; i++) send(16'd65025, 1'b0);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== ACCW'(131071) || out_count !== CW'(4) || out_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL saturation: valid=%0b sum=%0d cnt=%0d ovf=%0b required 1 131071 4 1",
               out_valid, out_sum, out_count, out_ovf);
    end
    take();
    send(16'd10, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== ACCW'(10) || out_count !== CW'(1) || out_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_next_group: valid=%0b sum=%0d cnt=%0d ovf=%0b required 1 10 1 0",
               out_valid, out_sum, out_count, out_ovf);
    end
    take();
  endtask

  task automatic test_backpressure();
    int accepts = 0;
    send(16'd20, 1'b0);
    send(16'd30, 1'b0);
    send(16'd40, 1'b1);
    in_valid = 1'b1;
    in_prod  = 16'd999;
    for (int i = 0; i < 10; i++) begin
      if (in_valid && in_ready) accepts++;
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== ACCW'(90) || out_count !== CW'(3) || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: valid=%0b sum=%0d cnt=%0d ready=%0b required 1 90 3 0",
                 i, out_valid, out_sum, out_count, in_ready);
      end
      tick();
    end
    vectors++;
    if (accepts != 0) begin
      miscompares++;
      $display("FAIL backpressure_accepts: accepts=%0d required 0", accepts);
    end
    take();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL backpressure_release: valid=%0b ready=%0b busy=%0b required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_clear();
    int seen_valid = 0;
    send(16'd50, 1'b0);
    send(16'd60, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    if (out_valid) seen_valid++;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_sum !== '0) begin
      miscompares++;
      $display("FAIL clear_state: busy=%0b ready=%0b sum=%0d required 0 0 0", busy, in_ready, out_sum);
    end
    tick();
    if (out_valid) seen_valid++;
    vectors++;
    if (in_ready !== 1'b1 || seen_valid != 0) begin
      miscompares++;
      $display("FAIL clear_recover: ready=%0b valid_seen=%0d required 1 0", in_ready, seen_valid);
    end
    send(16'd7, 1'b0);
    send(16'd8, 1'b1);
    vectors++;
    if (out_valid !== 1'b1 || out_sum !== ACCW'(15) || out_count !== CW'(2)) begin
      miscompares++;
      $display("FAIL clear_next_group: valid=%0b sum=%0d cnt=%0d required 1 15 2",
               out_valid, out_sum, out_count);
    end
    out_ready = 1'b1;
    clear     = 1'b1;
    tick();
    out_ready = 1'b0;
    clear     = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || out_sum !== '0 || out_count !== '0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_with_transfer: valid=%0b sum=%0d cnt=%0d busy=%0b required 0 0 0 0",
               out_valid, out_sum, out_count, busy);
    end
    tick();
  endtask

  task automatic test_random_groups();
    for (int g = 0; g < 40; g++) begin
      longint exp_sum = 0;
      int     exp_cnt = 0;
      bit     exp_ovf = 1'b0;
      bit     closed  = 1'b0;
      while (!closed) begin
        logic [15:0] p;
        logic        last;
        p    = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 300));
        last = ($urandom_range(0, 3) == 0);
        send(p, last);
        exp_cnt++;
        if (exp_sum + longint'(p) > MAXV) begin
          exp_sum = MAXV;
          exp_ovf = 1'b1;
        end else begin
          exp_sum = exp_sum + longint'(p);
        end
        closed = last || (exp_cnt == TERMS);
      end
      vectors++;
      if (out_valid !== 1'b1 || out_sum !== ACCW'(exp_sum) || out_count !== CW'(exp_cnt) || out_ovf !== exp_ovf) begin
        miscompares++;
        $display("FAIL random_group[%0d]: valid=%0b sum=%0d cnt=%0d ovf=%0b required 1 %0d %0d %0b",
                 g, out_valid, out_sum, out_count, out_ovf, exp_sum, exp_cnt, exp_ovf);
      end
      for (int d = $urandom_range(0, 3); d > 0; d--) tick();
      take();
    end
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_four_products();
    test_early_last();
    test_saturation();
    test_backpressure();
    test_clear();
    test_random_groups();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
